// File: rtl/arbiter_wrr_packet_hold.sv
// Weighted round-robin arbiter with optional packet locking (head flit to tail flit).
// A requester may complete up to its weight in packets in a row before priority rotates past it.
module arbiter_wrr_packet_hold #(
  parameter int NUM_REQS = 3,
  parameter int WEIGHT_W = 2,
  parameter bit HOLD_EN  = 1'b1,
  localparam int IDW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          requests,
  input  logic [NUM_REQS-1:0]          tail,
  input  logic                         advance,
  input  logic [NUM_REQS*WEIGHT_W-1:0] weights,
  output logic [NUM_REQS-1:0]          grants,
  output logic [IDW-1:0]               grant_id,
  output logic                         grant_valid,
  output logic                         locked
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_t;

  lock_t               lock_q, lock_d;
  logic [IDW-1:0]      owner_q, owner_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      last_q, last_d;
  logic [WEIGHT_W-1:0] used_q, used_d;

  logic                scan_found;
  logic [IDW-1:0]      scan_id;
  logic                gnt_any;
  logic [IDW-1:0]      gnt_id;
  logic                fire;
  logic                tl;
  logic [WEIGHT_W-1:0] eff_w;
  logic [WEIGHT_W:0]   n_cnt;

  // Rotating priority scan starting at ptr_q, wrapping modulo NUM_REQS.
  always_comb begin : scan
    int idx;
    scan_found = 1'b0;
    scan_id    = '0;
    idx        = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQS;
      if (!scan_found && requests[idx]) begin
        scan_found = 1'b1;
        scan_id    = IDW'(idx);
      end
    end
  end

  // Handshake: a grant is offered combinationally each cycle; the flit transfers
  // (fire) only when advance is high in a cycle with a grant. Grant does not wait on advance.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    if (lock_q == LOCKED) begin
      gnt_any = requests[owner_q];
      gnt_id  = owner_q;
    end else begin
      gnt_any = scan_found;
      gnt_id  = scan_id;
    end
  end

  assign fire = advance & gnt_any;
  assign tl   = tail[gnt_id] | ~HOLD_EN;

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    used_d  = used_q;
    eff_w   = weights[int'(gnt_id)*WEIGHT_W +: WEIGHT_W];
    if (eff_w == '0) eff_w = WEIGHT_W'(1);
    n_cnt   = (gnt_id == last_q) ? ({1'b0, used_q} + 1'b1) : (WEIGHT_W+1)'(1);
    if (fire) begin
      if (!tl) begin
        lock_d  = LOCKED;
        owner_d = gnt_id;
      end else begin
        // Packet complete: weight is only consulted here.
        lock_d = IDLE;
        last_d = gnt_id;
        if (n_cnt >= {1'b0, eff_w}) begin
          ptr_d  = (gnt_id == IDW'(NUM_REQS - 1)) ? '0 : gnt_id + IDW'(1);
          used_d = '0;
        end else begin
          ptr_d  = gnt_id;
          used_d = n_cnt[WEIGHT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q  <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      last_q  <= '0;
      used_q  <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      used_q  <= used_d;
    end
  end

  // Outputs are held at zero for the whole reset assertion, not just after the edge.
  assign grant_valid = gnt_any & ~reset;
  assign grants      = grant_valid ? (NUM_REQS'(1) << gnt_id) : '0;
  assign grant_id    = grant_valid ? gnt_id : '0;
  assign locked      = (lock_q == LOCKED) & ~reset;

endmodule
